// File: rtl/spi_pkg.sv
// spi_pkg: frame constants and FSM state encodings shared by the SPI master and slave
package spi_pkg;
    localparam int WORD_WIDTH_DEFAULT = 8;
    localparam int FRAME_BITS = 16;
    localparam int RW_BIT = 15;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_OVERRUN = 3'd4;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous input plus rise/fall detection
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // Retime the input and keep one delayed copy of the synced level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, d_i});
            prev_q <= level_o;
        end
    end
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: CPOL=0/CPHA=0 SPI responder with a register file, fabric read port and write notify
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_oe,
    input  logic [WORD_WIDTH-2:0] i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data,
    output logic                  o_wr_strobe,
    output logic [WORD_WIDTH-2:0] o_wr_addr,
    output logic [WORD_WIDTH-1:0] o_wr_data,
    output logic                  o_transaction_complete,
    output logic                  o_frame_error
);
    localparam int FB = 2 * WORD_WIDTH;
    localparam int AW = $clog2(NUM_REGS);
    localparam int BW = $clog2(WORD_WIDTH);
    localparam int CW = $clog2(FB + 1);

    logic                  sclk_rise, sclk_fall, sclk_level_unused;
    logic                  cs_level, cs_rise, cs_fall;
    logic                  mosi_level;
    logic [1:0]            mosi_edges_unused;
    logic [SYNC_STAGES:0]  settle_q;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FB-1:0]         shift_q, shift_d;
    logic                  miso_q, miso_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic [WORD_WIDTH-1:0] regs_q [NUM_REGS];
    logic [WORD_WIDTH-2:0] hdr_addr, wr_addr;
    logic [WORD_WIDTH-1:0] rd_val, wr_data;
    logic [BW-1:0]         bit_idx;
    logic                  frame_end, commit;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk_i(i_clock), .rst_i(i_reset), .d_i(SCLK),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk_i(i_clock), .rst_i(i_reset), .d_i(CS),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk_i(i_clock), .rst_i(i_reset), .d_i(MOSI),
        .level_o(mosi_level), .rise_o(mosi_edges_unused[0]), .fall_o(mosi_edges_unused[1])
    );

    // Header byte sits in the low half of the shifter right after the 8th bit; full frame at the end
    assign hdr_addr  = shift_q[WORD_WIDTH-2:0];
    assign wr_addr   = shift_q[FB-2:WORD_WIDTH];
    assign wr_data   = shift_q[WORD_WIDTH-1:0];
    assign rd_val    = (shift_q[WORD_WIDTH-1] && int'(hdr_addr) < NUM_REGS) ? regs_q[hdr_addr[AW-1:0]] : '0;
    assign bit_idx   = BW'(FB - 1 - int'(count_q));
    assign frame_end = state_q != ST_IDLE && cs_rise;
    assign commit    = frame_end && state_q == ST_DONE && !shift_q[FB-1] && int'(wr_addr) < NUM_REGS;
    assign MISO_oe   = ~cs_level;
    assign MISO      = miso_q & ~cs_level;

    // Frame FSM: a CS fall only starts a frame once the synchronisers hold real post-reset samples
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        miso_d  = miso_q;
        rdata_d = rdata_q;
        if (state_q == ST_IDLE) begin
            if (cs_fall && settle_q[SYNC_STAGES]) begin
                state_d = ST_ADDR;
                count_d = '0;
                miso_d  = 1'b0;
            end
        end else if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else if (sclk_rise) begin
            state_d = (state_q == ST_DONE || state_q == ST_OVERRUN) ? ST_OVERRUN :
                      count_q == CW'(FB - 1)         ? ST_DONE :
                      count_q == CW'(WORD_WIDTH - 1) ? ST_DATA : state_q;
            if (state_q == ST_ADDR || state_q == ST_DATA) begin
                shift_d = {shift_q[FB-2:0], mosi_level};
                count_d = count_q + 1'b1;
            end
        end else if (sclk_fall) begin
            rdata_d = (state_q == ST_DATA && count_q == CW'(WORD_WIDTH)) ? rd_val : rdata_q;
            miso_d  = state_q != ST_DATA ? 1'b0 :
                      count_q == CW'(WORD_WIDTH) ? rd_val[WORD_WIDTH-1] : rdata_q[bit_idx];
        end
    end

    // FSM state, shifter, MISO register and post-reset settle tracker
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shift_q  <= '0;
            miso_q   <= 1'b0;
            rdata_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            miso_q   <= miso_d;
            rdata_q  <= rdata_d;
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Register file, fabric read port and frame-end pulses, all updated on the same edge
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            regs_q                 <= '{default: '0};
            o_rd_data              <= '0;
            o_wr_strobe            <= 1'b0;
            o_wr_addr              <= '0;
            o_wr_data              <= '0;
            o_transaction_complete <= 1'b0;
            o_frame_error          <= 1'b0;
        end else begin
            if (commit) begin
                regs_q[wr_addr[AW-1:0]] <= wr_data;
                o_wr_addr               <= wr_addr;
                o_wr_data               <= wr_data;
            end
            o_rd_data              <= int'(i_rd_addr) < NUM_REGS ? regs_q[i_rd_addr[AW-1:0]] : '0;
            o_wr_strobe            <= commit;
            o_transaction_complete <= frame_end && state_q == ST_DONE;
            o_frame_error          <= frame_end && state_q != ST_DONE;
        end
    end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: bit-banged SPI master with a write/read scoreboard against a register model
module tb_spi_slave_regfile;
    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       SCLK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO, MISO_oe;
    logic [6:0] i_rd_addr = '0;
    logic [7:0] o_rd_data;
    logic       o_wr_strobe;
    logic [6:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_transaction_complete, o_frame_error;

    int          checks = 0, errors = 0;
    int          n_done = 0, n_strobe = 0, n_err = 0;
    int          h = 8;
    logic        last_oe;
    logic [7:0]  exp_regs [16];
    logic [14:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [14:0] e;

    spi_slave_regfile dut (
        .i_clock(i_clock), .i_reset(i_reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_wr_strobe(o_wr_strobe), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_transaction_complete(o_transaction_complete), .o_frame_error(o_frame_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and write scoreboard, sampled on the falling clock edge
    always @(negedge i_clock) begin
        if (o_transaction_complete) n_done++;
        if (o_frame_error) n_err++;
        if (o_wr_strobe) begin
            n_strobe++;
            check("wr_pending", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) begin
                e = exp_wr_q.pop_front();
                check("wr_addr", o_wr_addr, e[14:8]);
                check("wr_data", o_wr_data, e[7:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic clear_model;
        foreach (exp_regs[i]) exp_regs[i] = 8'h00;
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        CS = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        wait_cyc(4);
        i_reset = 1'b0;
        clear_model();
        wait_cyc(5);
    endtask

    // One frame of nbits; rst_at >= 0 pulses i_reset just before that bit with CS held low
    task automatic spi_xfer(input logic [15:0] tx, input int nbits, input int rst_at, output logic [15:0] rx);
        logic [15:0] sh;
        sh = tx;
        rx = '0;
        CS = 1'b0;
        SCLK = 1'b0;
        MOSI = sh[15];
        wait_cyc(h);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                i_reset = 1'b1;
                wait_cyc(3);
                i_reset = 1'b0;
                clear_model();
                wait_cyc(h);
            end
            if (i < 16) rx = {rx[14:0], MISO};
            if (i == 0) last_oe = MISO_oe;
            SCLK = 1'b1;
            wait_cyc(h);
            SCLK = 1'b0;
            sh = sh << 1;
            MOSI = sh[15];
            wait_cyc(h);
        end
        CS = 1'b1;
        wait_cyc(2 * h + 4);
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        int c0, s0, e0;
        logic [15:0] rx;
        c0 = n_done;
        s0 = n_strobe;
        e0 = n_err;
        if (a < 16) begin
            exp_wr_q.push_back({7'(a), d});
            exp_regs[a] = d;
        end
        spi_xfer({1'b0, 7'(a), d}, 16, -1, rx);
        check("wr_complete", n_done - c0, 1);
        check("wr_strobe_cnt", n_strobe - s0, a < 16 ? 1 : 0);
        check("wr_no_err", n_err - e0, 0);
    endtask

    task automatic do_read(input int a);
        int c0, s0;
        logic [15:0] rx;
        logic [7:0] x;
        c0 = n_done;
        s0 = n_strobe;
        exp_rd_q.push_back(a < 16 ? exp_regs[a] : 8'h00);
        spi_xfer({1'b1, 7'(a), 8'h00}, 16, -1, rx);
        x = exp_rd_q.pop_front();
        check("rd_miso", rx[7:0], x);
        check("rd_upper", rx[15:8], 0);
        check("rd_oe", last_oe, 1);
        check("rd_complete", n_done - c0, 1);
        check("rd_no_strobe", n_strobe - s0, 0);
    endtask

    task automatic do_bad(input logic [15:0] tx, input int nbits);
        int c0, s0, e0;
        logic [15:0] rx;
        c0 = n_done;
        s0 = n_strobe;
        e0 = n_err;
        spi_xfer(tx, nbits, -1, rx);
        check("bad_err", n_err - e0, 1);
        check("bad_no_complete", n_done - c0, 0);
        check("bad_no_strobe", n_strobe - s0, 0);
    endtask

    task automatic fab_read(input int a, input logic [7:0] x);
        i_rd_addr = 7'(a);
        wait_cyc(1);
        check("fab_rd", o_rd_data, x);
    endtask

    initial begin
        int c0, s0, e0;
        logic [15:0] rx;
        logic found;
        do_reset();
        check("rst_miso", MISO, 0);
        check("rst_oe", MISO_oe, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_strobe", o_wr_strobe, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_complete", o_transaction_complete, 0);
        check("rst_error", o_frame_error, 0);
        // Basic write, fabric readback and SPI readback
        do_write(5, 8'hA7);
        fab_read(5, 8'hA7);
        do_read(5);
        // Fresh reset: out-of-range writes dropped, reads return zero
        do_reset();
        check("rst2_wr_addr", o_wr_addr, 0);
        check("rst2_wr_data", o_wr_data, 0);
        fab_read(5, 8'h00);
        do_read(15);
        do_write(32, 8'h55);
        do_read(32);
        fab_read(32, 8'h00);
        // Short and long frames raise an error and never write
        do_bad(16'h03FF, 11);
        fab_read(3, 8'h00);
        do_bad(16'h0477, 18);
        fab_read(4, 8'h00);
        // Reset mid-frame with CS low: silent abort, then re-arm on the next CS cycle
        do_write(1, 8'h11);
        c0 = n_done;
        s0 = n_strobe;
        e0 = n_err;
        spi_xfer(16'h013C, 16, 9, rx);
        check("abort_no_complete", n_done - c0, 0);
        check("abort_no_strobe", n_strobe - s0, 0);
        check("abort_no_err", n_err - e0, 0);
        fab_read(1, 8'h00);
        do_write(1, 8'h3C);
        fab_read(1, 8'h3C);
        // Minimum SCLK half-period, back-to-back over the whole register file
        h = 5;
        for (int n = 0; n < 16; n++) do_write(n, 8'(8'h10 + n));
        for (int n = 0; n < 16; n++) do_read(n);
        for (int n = 0; n < 16; n++) fab_read(n, 8'(8'h10 + n));
        // SPI write and fabric read of the same register on the same edge
        i_rd_addr = 7'd2;
        exp_wr_q.push_back({7'd2, 8'h99});
        exp_regs[2] = 8'h99;
        found = 1'b0;
        fork
            spi_xfer(16'h0299, 16, -1, rx);
            begin
                for (int k = 0; k < 400 && !found; k++) begin
                    @(negedge i_clock);
                    if (o_wr_strobe) found = 1'b1;
                end
                check("coincide_seen", found, 1);
                if (found) begin
                    check("coincide_old", o_rd_data, 8'h12);
                    @(negedge i_clock);
                    check("coincide_new", o_rd_data, 8'h99);
                end
            end
        join
        check("wr_q_empty", exp_wr_q.size(), 0);
        check("held_addr", o_wr_addr, 2);
        check("held_data", o_wr_data, 8'h99);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
